// File: rtl/sc_spil_fifo.sv
// ---------------------------------------------------------------------------
// sc_spil_fifo -- register-mapped TX/RX FIFO pair with interrupt status.
//
// A host writes the TX FIFO through a register port; the core drains it
// over a valid/ready stream. The core fills the RX FIFO with a push strobe
// and the host drains it by reading the RXD register.
//
// Register map (decoded on address bits [11:2]):
//   0x00 TXD  write pushes TX, reads 0
//   0x04 RXD  read pops RX (empty read returns 0, flags RXUNF)
//   0x08 FST  status: [0] TXEMPTY [1] TXFULL [2] RXEMPTY [3] RXFULL
//             [15:8] TX level [23:16] RX level
//   0x0C FIS  interrupt status, write-1-to-clear
//             [0] TXOVF [1] RXUNF [2] RXOVF [3] TXTHR [4] RXTHR
//   0x10 FIE  interrupt enable (byte enables honoured)
//   0x14 FTH  thresholds [7:0] TXTH [15:8] RXTH (byte enables honoured)
//   0x18 FCTL [0] TXCLR [1] RXCLR, reads 0
//
// Build option: define SC_SPIL_FIFO_THRESH_EN to include the FTH register
// and the TXTHR/RXTHR status bits. Without it FTH reads 0 and ignores writes.
//
// Ports:
//   SYSCLK, SYSRST            clock, synchronous active-high reset
//   REG_WADR/REG_WENB/REG_WDAT register write (any byte enable = write)
//   REG_RADR/REG_RENB         register read strobe
//   REG_RDAT                  read data, valid the cycle after REG_RENB
//   TXDATA/TXVALID/TXREADY    TX stream towards the core
//   RXDATA/RXVALID            RX push from the core (no backpressure)
//   INTERRUPT                 OR of (FIS AND FIE)
//
// Handshake: a TX transfer happens on a rising edge where TXVALID and
// TXREADY are both high; TXVALID and TXDATA hold until then and TXREADY
// with TXVALID low has no effect. RXVALID is an unconditional push request;
// a push into a full RX FIFO is dropped and reported through FIS.RXOVF.
// ---------------------------------------------------------------------------

// Single-clock FIFO queue. Full/empty are judged on pre-edge state, so a
// push to a full queue is refused even when a pop happens in the same cycle.
// clr empties the queue and overrides any push or pop of that cycle.
module sc_spil_fifo_q #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign level   = level_q;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Storage is never reset; only the write itself is suppressed during reset.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= wdata;
  end
endmodule

module sc_spil_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic [31:0]       REG_WADR,
  input  logic [3:0]        REG_WENB,
  input  logic [31:0]       REG_WDAT,
  input  logic [31:0]       REG_RADR,
  input  logic              REG_RENB,
  output logic [31:0]       REG_RDAT,
  output logic [DATA_W-1:0] TXDATA,
  output logic              TXVALID,
  input  logic              TXREADY,
  input  logic [DATA_W-1:0] RXDATA,
  input  logic              RXVALID,
  output logic              INTERRUPT
);
  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [9:0] A_TXD  = 10'h000;
  localparam logic [9:0] A_RXD  = 10'h001;
  localparam logic [9:0] A_FST  = 10'h002;
  localparam logic [9:0] A_FIS  = 10'h003;
  localparam logic [9:0] A_FIE  = 10'h004;
  localparam logic [9:0] A_FTH  = 10'h005;
  localparam logic [9:0] A_FCTL = 10'h006;

  logic [9:0]        wr_idx;
  logic [9:0]        rd_idx;
  logic              wr_en;
  logic              txd_wr;
  logic              fis_wr;
  logic              fie_wr;
  logic              fctl_wr;
  logic              rxd_rd;

  logic [DATA_W-1:0] tx_rdata;
  logic [DATA_W-1:0] rx_rdata;
  logic [LW-1:0]     tx_level;
  logic [LW-1:0]     rx_level;
  logic              tx_empty;
  logic              tx_full;
  logic              rx_empty;
  logic              rx_full;

  logic [4:0]        fis_q;
  logic [4:0]        fie_q;
  logic [4:0]        fis_set;
  logic [4:0]        fis_w1c;
  logic              tx_thr;
  logic              rx_thr;
  logic [31:0]       fth_rd;
  logic [31:0]       fst_rd;
  logic [31:0]       rd_val;

  assign wr_idx  = REG_WADR[11:2];
  assign rd_idx  = REG_RADR[11:2];
  assign wr_en   = |REG_WENB;
  assign txd_wr  = wr_en && (wr_idx == A_TXD);
  assign fis_wr  = wr_en && (wr_idx == A_FIS);
  assign fie_wr  = wr_en && (wr_idx == A_FIE);
  assign fctl_wr = wr_en && (wr_idx == A_FCTL);
  assign rxd_rd  = REG_RENB && (rd_idx == A_RXD);

  sc_spil_fifo_q #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk   (SYSCLK),
    .rst   (SYSRST),
    .clr   (fctl_wr && REG_WDAT[0]),
    .push  (txd_wr),
    .pop   (TXREADY),
    .wdata (REG_WDAT[DATA_W-1:0]),
    .rdata (tx_rdata),
    .level (tx_level),
    .empty (tx_empty),
    .full  (tx_full)
  );

  sc_spil_fifo_q #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk   (SYSCLK),
    .rst   (SYSRST),
    .clr   (fctl_wr && REG_WDAT[1]),
    .push  (RXVALID),
    .pop   (rxd_rd),
    .wdata (RXDATA),
    .rdata (rx_rdata),
    .level (rx_level),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign TXDATA  = tx_rdata;
  assign TXVALID = !tx_empty;

`ifdef SC_SPIL_FIFO_THRESH_EN
  logic        fth_wr;
  logic [15:0] fth_q;

  assign fth_wr = wr_en && (wr_idx == A_FTH);

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      fth_q <= '0;
    end else if (fth_wr) begin
      if (REG_WENB[0]) fth_q[7:0]  <= REG_WDAT[7:0];
      if (REG_WENB[1]) fth_q[15:8] <= REG_WDAT[15:8];
    end
  end

  // RXTH of 0 disables the RX threshold; TXTH of 0 still fires on empty TX.
  assign tx_thr = (8'(tx_level) <= fth_q[7:0]);
  assign rx_thr = (fth_q[15:8] != 8'h00) && (8'(rx_level) >= fth_q[15:8]);
  assign fth_rd = {16'h0000, fth_q};
`else
  assign tx_thr = 1'b0;
  assign rx_thr = 1'b0;
  assign fth_rd = 32'h0000_0000;
`endif

  // Hardware events are OR-ed in after the W1C mask so a same-cycle event
  // survives the clear.
  assign fis_set = {rx_thr, tx_thr, RXVALID && rx_full, rxd_rd && rx_empty, txd_wr && tx_full};
  assign fis_w1c = fis_wr ? REG_WDAT[4:0] : 5'b00000;

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      fis_q <= '0;
      fie_q <= '0;
    end else begin
      fis_q <= (fis_q & ~fis_w1c) | fis_set;
      if (fie_wr && REG_WENB[0]) fie_q <= REG_WDAT[4:0];
    end
  end

  assign INTERRUPT = |(fis_q & fie_q);

  assign fst_rd = {8'h00, 8'(rx_level), 8'(tx_level), 4'h0, rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rd_val = 32'h0000_0000;
    case (rd_idx)
      A_RXD:   rd_val = rx_empty ? 32'h0000_0000 : 32'(rx_rdata);
      A_FST:   rd_val = fst_rd;
      A_FIS:   rd_val = 32'(fis_q);
      A_FIE:   rd_val = 32'(fie_q);
      A_FTH:   rd_val = fth_rd;
      default: rd_val = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      REG_RDAT <= '0;
    end else if (REG_RENB) begin
      REG_RDAT <= rd_val;
    end
  end

  // Address bits outside [11:2] and write-data bits beyond the used fields
  // carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{REG_WADR[31:12], REG_WADR[1:0], REG_RADR[31:12], REG_RADR[1:0], REG_WDAT};
endmodule

// File: tb/tb_sc_spil_fifo.sv
// ---------------------------------------------------------------------------
// tb_sc_spil_fifo -- self-checking bench for sc_spil_fifo (DATA_W=32,
// DEPTH=16). A table of single-cycle vectors covers register decode and the
// basic FIFO paths; hand-written sequences cover fill/overflow, draining,
// simultaneous push/pop, clears, reset abort and (when built with
// SC_SPIL_FIFO_THRESH_EN) the threshold status bits.
// ---------------------------------------------------------------------------
module tb_sc_spil_fifo;
  localparam logic [31:0] A_TXD  = 32'h00;
  localparam logic [31:0] A_RXD  = 32'h04;
  localparam logic [31:0] A_FST  = 32'h08;
  localparam logic [31:0] A_FIS  = 32'h0C;
  localparam logic [31:0] A_FIE  = 32'h10;
  localparam logic [31:0] A_FTH  = 32'h14;
  localparam logic [31:0] A_FCTL = 32'h18;

`ifdef SC_SPIL_FIFO_THRESH_EN
  // TXTHR fires whenever TX is at or below TXTH, so only bits [2:0] are
  // compared in the general sequences.
  localparam logic [31:0] FIS_MASK = 32'h0000_0007;
  localparam bit          THR_ON   = 1'b1;
`else
  localparam logic [31:0] FIS_MASK = 32'hFFFF_FFFF;
  localparam bit          THR_ON   = 1'b0;
`endif

  logic        SYSCLK;
  logic        SYSRST;
  logic [31:0] REG_WADR;
  logic [3:0]  REG_WENB;
  logic [31:0] REG_WDAT;
  logic [31:0] REG_RADR;
  logic        REG_RENB;
  logic [31:0] REG_RDAT;
  logic [31:0] TXDATA;
  logic        TXVALID;
  logic        TXREADY;
  logic [31:0] RXDATA;
  logic        RXVALID;
  logic        INTERRUPT;

  int total = 0;
  int bad   = 0;

  sc_spil_fifo #(.DATA_W(32), .DEPTH(16)) dut (
    .SYSCLK    (SYSCLK),
    .SYSRST    (SYSRST),
    .REG_WADR  (REG_WADR),
    .REG_WENB  (REG_WENB),
    .REG_WDAT  (REG_WDAT),
    .REG_RADR  (REG_RADR),
    .REG_RENB  (REG_RENB),
    .REG_RDAT  (REG_RDAT),
    .TXDATA    (TXDATA),
    .TXVALID   (TXVALID),
    .TXREADY   (TXREADY),
    .RXDATA    (RXDATA),
    .RXVALID   (RXVALID),
    .INTERRUPT (INTERRUPT)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic idle_inputs();
    REG_WADR = '0; REG_WENB = '0; REG_WDAT = '0;
    REG_RADR = '0; REG_RENB = 1'b0;
    TXREADY  = 1'b0; RXVALID = 1'b0; RXDATA = '0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    REG_WADR = a; REG_WDAT = d; REG_WENB = be;
    tick();
    REG_WENB = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    REG_RADR = a; REG_RENB = 1'b1;
    tick();
    REG_RENB = 1'b0;
    d = REG_RDAT;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp,
                        input logic [31:0] mask);
    logic [31:0] d;
    rd(a, d);
    check(nm, d & mask, exp);
  endtask

  task automatic rx_push(input logic [31:0] d);
    RXVALID = 1'b1; RXDATA = d;
    tick();
    RXVALID = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] adr;
    logic [3:0]  wenb;
    logic [31:0] wdat;
    logic        renb;
    logic        txready;
    logic        rxvalid;
    logic [31:0] rxdata;
    logic        chk_rd;
    logic [31:0] exp_rdat;
    logic        exp_txvalid;
    logic [31:0] exp_txdata;
    logic        exp_int;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] adr, logic [3:0] wenb, logic [31:0] wdat,
                              logic renb, logic txready, logic rxvalid, logic [31:0] rxdata,
                              logic chk_rd, logic [31:0] exp_rdat, logic exp_txvalid,
                              logic [31:0] exp_txdata, logic exp_int);
    vec_t v;
    v.adr = adr; v.wenb = wenb; v.wdat = wdat; v.renb = renb;
    v.txready = txready; v.rxvalid = rxvalid; v.rxdata = rxdata;
    v.chk_rd = chk_rd; v.exp_rdat = exp_rdat; v.exp_txvalid = exp_txvalid;
    v.exp_txdata = exp_txdata; v.exp_int = exp_int;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  // Expected RX read-back values in push order.
  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] d;
    idle_inputs();

    //            adr     wenb  wdat          rd tr rv rxdata  chk exp_rdat       txv txdata  int
    vecs.push_back(mk(A_TXD,  4'hF, 32'h0000_00A5, 0, 0, 0, 32'h0, 0, 32'h0,          1, 32'hA5, 0));
    vecs.push_back(mk(A_TXD,  4'hF, 32'h0000_005A, 0, 0, 0, 32'h0, 0, 32'h0,          1, 32'hA5, 0));
    vecs.push_back(mk(A_FST,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0204,  1, 32'hA5, 0));
    vecs.push_back(mk(A_TXD,  4'h0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,          1, 32'h5A, 0));
    vecs.push_back(mk(A_TXD,  4'h0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_TXD,  4'h0, 32'h0,         0, 1, 0, 32'h0, 0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_FST,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0005,  0, 32'h0,  0));
    vecs.push_back(mk(A_TXD,  4'h0, 32'h0,         0, 0, 1, 32'h33,0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_TXD,  4'h0, 32'h0,         0, 0, 1, 32'h44,0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_FST,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0002_0001,  0, 32'h0,  0));
    vecs.push_back(mk(A_RXD,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0033,  0, 32'h0,  0));
    vecs.push_back(mk(A_RXD,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0044,  0, 32'h0,  0));
    vecs.push_back(mk(A_FST,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0005,  0, 32'h0,  0));
    vecs.push_back(mk(A_FIE,  4'h2, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_FIE,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0000,  0, 32'h0,  0));
    vecs.push_back(mk(A_FIE,  4'h1, 32'h0000_0002, 0, 0, 0, 32'h0, 0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_FIE,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0002,  0, 32'h0,  0));
    vecs.push_back(mk(A_TXD,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0000,  0, 32'h0,  0));
    vecs.push_back(mk(A_FIE,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0002,  0, 32'h0,  0));
    vecs.push_back(mk(A_FCTL, 4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0000,  0, 32'h0,  0));
    vecs.push_back(mk(32'h1C, 4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0000,  0, 32'h0,  0));
    vecs.push_back(mk(32'h100,4'h0, 32'h0,         1, 0, 0, 32'h0, 1, 32'h0000_0000,  0, 32'h0,  0));
    vecs.push_back(mk(A_FTH,  4'hF, 32'h0000_0302, 0, 0, 0, 32'h0, 0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_FTH,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, THR_ON ? 32'h0302 : 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(A_FTH,  4'h2, 32'hFFFF_0500, 0, 0, 0, 32'h0, 0, 32'h0,          0, 32'h0,  0));
    vecs.push_back(mk(A_FTH,  4'h0, 32'h0,         1, 0, 0, 32'h0, 1, THR_ON ? 32'h0502 : 32'h0, 0, 32'h0, 0));

    // ---- reset ----
    SYSRST = 1'b1;
    tick(); tick();
    SYSRST = 1'b0;
    check("rst_txvalid",   32'(TXVALID),   32'h0);
    check("rst_interrupt", 32'(INTERRUPT), 32'h0);
    check("rst_rdat",      REG_RDAT,       32'h0);
    rd_chk("rst_fst", A_FST, 32'h0000_0005, 32'hFFFF_FFFF);
    rd_chk("rst_fis", A_FIS, 32'h0, FIS_MASK);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      REG_WADR = vecs[i].adr;  REG_RADR = vecs[i].adr;
      REG_WENB = vecs[i].wenb; REG_WDAT = vecs[i].wdat;
      REG_RENB = vecs[i].renb; TXREADY  = vecs[i].txready;
      RXVALID  = vecs[i].rxvalid; RXDATA = vecs[i].rxdata;
      tick();
      idle_inputs();
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdat", i), REG_RDAT, vecs[i].exp_rdat);
      check($sformatf("vec%0d_txvalid", i), 32'(TXVALID), 32'(vecs[i].exp_txvalid));
      if (vecs[i].exp_txvalid) check($sformatf("vec%0d_txdata", i), TXDATA, vecs[i].exp_txdata);
      check($sformatf("vec%0d_int", i), 32'(INTERRUPT), 32'(vecs[i].exp_int));
    end

    // ---- RX underflow raises RXUNF and the interrupt (FIE=0x2) ----
    rd_chk("unf_pre_fie", A_FIE, 32'h2, 32'hFFFF_FFFF);
    rd_chk("unf_rdat", A_RXD, 32'h0, 32'hFFFF_FFFF);
    check("unf_int_set", 32'(INTERRUPT), 32'h1);
    rd_chk("unf_fis", A_FIS, 32'h2, FIS_MASK);
    wr(A_FIS, 32'h2, 4'hF);
    check("unf_int_clr", 32'(INTERRUPT), 32'h0);
    rd_chk("unf_fis_clr", A_FIS, 32'h0, FIS_MASK);

    // ---- TX fill past full: 17 writes, the 17th is dropped ----
    for (int i = 1; i <= 17; i++) wr(A_TXD, 32'(i), 4'hF);
    rd_chk("txfull_fst", A_FST, 32'h0000_1006, 32'hFFFF_FFFF);
    rd_chk("txfull_fis", A_FIS, 32'h1, FIS_MASK);
    check("txfull_int", 32'(INTERRUPT), 32'h0);

    // ---- drain TX: 0x1..0x10 in order, 0x11 never appears ----
    TXREADY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain%0d_txvalid", i), 32'(TXVALID), 32'h1);
      check($sformatf("drain%0d_txdata", i), TXDATA, 32'(i));
      tick();
    end
    TXREADY = 1'b0;
    check("drain_txvalid_end", 32'(TXVALID), 32'h0);
    rd_chk("drain_fst", A_FST, 32'h0000_0005, 32'hFFFF_FFFF);
    wr(A_FIS, 32'h1F, 4'hF);

    // ---- RX overflow, then RXCLR ----
    for (int i = 0; i <= 16; i++) rx_push(32'h100 + 32'(i));
    rd_chk("rxfull_fst", A_FST, 32'h0010_0009, 32'hFFFF_FFFF);
    rd_chk("rxfull_fis", A_FIS, 32'h4, FIS_MASK);
    check("rxovf_int_masked", 32'(INTERRUPT), 32'h0);
    wr(A_FCTL, 32'h2, 4'hF);
    rd_chk("rxclr_fst", A_FST, 32'h0000_0005, 32'hFFFF_FFFF);
    wr(A_FIS, 32'h1F, 4'hF);

    // ---- RX simultaneous push and pop at level 3 ----
    exp_q.delete();
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    for (int i = 0; i < 3; i++) rx_push(exp_q[i]);
    RXVALID = 1'b1; RXDATA = exp_q[3];
    REG_RADR = A_RXD; REG_RENB = 1'b1;
    tick();
    idle_inputs();
    check("pp_rdat", REG_RDAT, exp_q.pop_front());
    rd_chk("pp_fst", A_FST, 32'h0003_0001, 32'hFFFF_FFFF);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      rd_chk($sformatf("pp_drain_%0h", e), A_RXD, e, 32'hFFFF_FFFF);
    end
    rd_chk("pp_fst_end", A_FST, 32'h0000_0005, 32'hFFFF_FFFF);

    // ---- TXCLR together with TXREADY, RX untouched ----
    for (int i = 0; i < 5; i++) wr(A_TXD, 32'h50 + 32'(i), 4'hF);
    rx_push(32'h61);
    rx_push(32'h62);
    REG_WADR = A_FCTL; REG_WDAT = 32'h1; REG_WENB = 4'hF; TXREADY = 1'b1;
    tick();
    idle_inputs();
    check("txclr_txvalid", 32'(TXVALID), 32'h0);
    rd_chk("txclr_fst", A_FST, 32'h0002_0001, 32'hFFFF_FFFF);
    rd_chk("txclr_rx0", A_RXD, 32'h61, 32'hFFFF_FFFF);
    rd_chk("txclr_rx1", A_RXD, 32'h62, 32'hFFFF_FFFF);

    // ---- push into full TX with a same-cycle pop is refused ----
    for (int i = 0; i < 16; i++) wr(A_TXD, 32'h70 + 32'(i), 4'hF);
    REG_WADR = A_TXD; REG_WDAT = 32'h99; REG_WENB = 4'hF; TXREADY = 1'b1;
    tick();
    idle_inputs();
    check("fullpp_txdata", TXDATA, 32'h71);
    rd_chk("fullpp_fst", A_FST, 32'h0000_0F04, 32'hFFFF_FFFF);
    rd_chk("fullpp_fis", A_FIS, 32'h1, FIS_MASK);
    wr(A_FCTL, 32'h3, 4'hF);
    wr(A_FIS, 32'h1F, 4'hF);
    check("fullpp_clr_txvalid", 32'(TXVALID), 32'h0);

    // ---- reset aborts transfers and clears registers ----
    wr(A_TXD, 32'hAB, 4'hF);
    wr(A_FIE, 32'h1F, 4'h1);
    rd_chk("prerst_fie", A_FIE, 32'h1F, 32'hFFFF_FFFF);
    SYSRST = 1'b1; TXREADY = 1'b1; RXVALID = 1'b1; RXDATA = 32'h77;
    tick();
    SYSRST = 1'b0;
    idle_inputs();
    check("rst2_txvalid", 32'(TXVALID), 32'h0);
    check("rst2_rdat", REG_RDAT, 32'h0);
    check("rst2_int", 32'(INTERRUPT), 32'h0);
    rd_chk("rst2_fst", A_FST, 32'h0000_0005, 32'hFFFF_FFFF);
    rd_chk("rst2_fie", A_FIE, 32'h0, 32'hFFFF_FFFF);

`ifdef SC_SPIL_FIFO_THRESH_EN
    // ---- RX threshold: set persists across a W1C while the level holds ----
    wr(A_FTH, 32'h0000_0402, 4'hF);
    rd_chk("thr_fth", A_FTH, 32'h0402, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) rx_push(32'h200 + 32'(i));
    tick();
    rd_chk("thr_rxthr_set", A_FIS, 32'h10, 32'h10);
    wr(A_FIS, 32'h10, 4'hF);
    rd_chk("thr_rxthr_held", A_FIS, 32'h10, 32'h10);
    rd_chk("thr_fst", A_FST, 32'h0004_0001, 32'hFFFF_FFFF);
`else
    // ---- threshold logic absent: bits 3/4 never set, FTH reads 0 ----
    for (int i = 0; i < 4; i++) rx_push(32'h200 + 32'(i));
    tick();
    rd_chk("nothr_fis", A_FIS, 32'h0, 32'hFFFF_FFFF);
    rd_chk("nothr_fth", A_FTH, 32'h0, 32'hFFFF_FFFF);
`endif

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sc_spil_fifo.md
SC_SPIL_FIFO -- requirements
Module: sc_spil_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: FIFO entry width in bits, legal range 8..32.
REQ-002 SHALL have parameter DEPTH, default 16: entries per FIFO, a power of two, legal range 2..128.
REQ-003 SHALL have port SYSCLK, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port SYSRST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have register write ports REG_WADR (input, 32, byte address), REG_WENB (input, 4, byte enables) and REG_WDAT (input, 32, write data).
REQ-006 SHALL have register read ports REG_RADR (input, 32, byte address), REG_RENB (input, 1, read strobe) and REG_RDAT (output, 32, registered read data).
REQ-007 SHALL have port TXDATA, output, DATA_W bits: TX FIFO head entry.
REQ-008 SHALL have port TXVALID, output, 1 bit: TX FIFO is not empty.
REQ-009 SHALL have port TXREADY, input, 1 bit: the core pops the TX head.
REQ-010 SHALL have port RXDATA, input, DATA_W bits: data from the core.
REQ-011 SHALL have port RXVALID, input, 1 bit: push RXDATA.
REQ-012 SHALL have port INTERRUPT, output, 1 bit: equals OR of (FIS AND FIE).

Function
REQ-013 SHALL decode addresses on bits [11:2] with this map:
- 0x00 TXD: write-only push; reads 0.
- 0x04 RXD: read pops.
- 0x08 FST: read-only status.
- 0x0C FIS: write-1-to-clear interrupt status.
- 0x10 FIE: interrupt enable.
- 0x14 FTH: thresholds.
- 0x18 FCTL: clear controls.
REQ-014 SHALL return REG_RDAT one cycle after a REG_RENB hit, and 0 for unmapped addresses.
REQ-015 SHALL treat a write as any REG_WENB bit set; TXD, FCTL and FIS SHALL use REG_WDAT as a whole word, while FIE and FTH SHALL honour byte enables.
REQ-016 SHALL, on a TXD write with TX not full, push REG_WDAT[DATA_W-1:0]; if TX is full it SHALL drop the data and set FIS.TXOVF (bit 0).
REQ-017 SHALL pop TX when TXVALID and TXREADY are both high; TXREADY while TXVALID is low SHALL be ignored.
REQ-018 SHALL, on an RXVALID push with RX full, drop the data and set FIS.RXOVF (bit 2); otherwise it SHALL store the data.
REQ-019 SHALL, on an RXD read with RX not empty, return the head zero-extended to 32 bits and pop; with RX empty it SHALL return 0 and set FIS.RXUNF (bit 1).
REQ-020 SHALL evaluate full and empty on pre-edge state: a push to a full FIFO is rejected even if a pop occurs in the same cycle; a simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the level unchanged.
REQ-021 SHALL keep read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, and a level counter of clog2(DEPTH)+1 bits.
REQ-022 SHALL lay out FST as:
- [0] TXEMPTY, [1] TXFULL, [2] RXEMPTY, [3] RXFULL;
- [15:8] TX level, [23:16] RX level;
- all other bits 0.
REQ-023 SHALL, on an FCTL write, empty TX when bit0 (TXCLR) is 1 and RX when bit1 (RXCLR) is 1, in the next cycle; a clear SHALL win over a simultaneous push or pop, and FCTL SHALL read 0.
REQ-024 SHALL give a hardware set of an FIS bit priority over a W1C of the same bit in the same cycle.

Reset
REQ-025 SHALL, on SYSRST high at a clock edge, empty both FIFOs and zero FIS, FIE, FTH and REG_RDAT; TXVALID and INTERRUPT SHALL then be 0 and FST SHALL read 0x0000_0005.
REQ-026 SHALL abort any transfer in progress on reset, with no pop and no push.
REQ-027 SHALL NOT clear FIFO storage contents on reset; only pointers and levels are reset.

Configuration
REQ-028 SHALL gate the threshold feature with macro SC_SPIL_FIFO_THRESH_EN.
REQ-029 SHALL, when SC_SPIL_FIFO_THRESH_EN is defined:
- FTH SHALL hold TXTH in [7:0] and RXTH in [15:8];
- FIS.TXTHR (bit 3) SHALL be set every cycle that TX level <= TXTH;
- FIS.RXTHR (bit 4) SHALL be set every cycle that RXTH != 0 and RX level >= RXTH;
- the set condition SHALL persist over a W1C.
REQ-030 SHALL, when SC_SPIL_FIFO_THRESH_EN is undefined: FTH reads 0, writes to it are ignored, FIS bits 3 and 4 stay 0, and no threshold logic is present.

Verification
REQ-031 SHALL cover: DEPTH=16, 17 TXD writes 0x1..0x11 with TXREADY=0 -> FST TX level 16, TXFULL=1, FIS=0x1, and 0x11 absent from the FIFO.
REQ-032 SHALL cover: pop all 16 entries with TXREADY=1 -> TXDATA sequence 0x1..0x10, then TXVALID=0 and TXEMPTY=1.
REQ-033 SHALL cover: RXD read with RX empty -> REG_RDAT=0 one cycle later and FIS bit1=1; with FIE=0x2, INTERRUPT=1; a W1C of 0x2 -> INTERRUPT=0.
REQ-034 SHALL cover: RX holding 3 entries, RXVALID push and RXD read in the same cycle -> RX level stays 3 and the read returns the oldest entry.
REQ-035 SHALL cover: TX holding 5 entries, FCTL=0x1 written together with TXREADY=1 -> TX level 0 the next cycle and RX unaffected.
REQ-036 SHALL cover, with SC_SPIL_FIFO_THRESH_EN defined: FTH=0x0402, RX filled to 4 -> FIS bit4=1; W1C of 0x10 while RX level is 4 -> bit4 remains 1.
